// File: rtl/mem_1r1w_sched.sv
// Scheduler and initializer in front of one 1R1W memory atom: round-robin sharing of the
// read and write ports between two requesters each, an optional init sweep, and read routing.
module mem_1r1w_sched #(
    parameter int NUMADDR    = 8,
    parameter int BITADDR    = 3,
    parameter int BITDATA    = 1,
    parameter int SRAM_DELAY = 0,
    parameter int RSTINIT    = 0,
    parameter int RSTSTRT    = 0,
    parameter int RSTINCR    = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               ready,
    input  logic               rd_req_0,
    input  logic               rd_req_1,
    input  logic [BITADDR-1:0] rd_adr_0,
    input  logic [BITADDR-1:0] rd_adr_1,
    output logic               rd_gnt_0,
    output logic               rd_gnt_1,
    output logic               rd_vld_0,
    output logic               rd_vld_1,
    output logic [BITDATA-1:0] rd_dout_0,
    output logic [BITDATA-1:0] rd_dout_1,
    input  logic               wr_req_0,
    input  logic               wr_req_1,
    input  logic [BITADDR-1:0] wr_adr_0,
    input  logic [BITADDR-1:0] wr_adr_1,
    input  logic [BITDATA-1:0] wr_din_0,
    input  logic [BITDATA-1:0] wr_din_1,
    output logic               wr_gnt_0,
    output logic               wr_gnt_1,
    output logic               mem_read,
    output logic [BITADDR-1:0] mem_rd_adr,
    input  logic [BITDATA-1:0] mem_rd_dout,
    output logic               mem_write,
    output logic [BITADDR-1:0] mem_wr_adr,
    output logic [BITDATA-1:0] mem_wr_din
);

    typedef enum logic [1:0] {ST_RST, ST_INIT, ST_RUN} state_t;

    // Counter is one bit wider than the address so a full power-of-two sweep terminates.
    localparam logic [BITADDR:0] LAST_ADR = (BITADDR+1)'(NUMADDR - 1);

    state_t             r_state;
    logic [BITADDR:0]   r_icnt;
    logic               r_ready;
    logic               r_wp;
    logic               r_rp;

    logic               w_run;
    logic               w_init;
    logic [BITDATA-1:0] w_init_din;
    logic               w_wr_win;
    logic               w_wr_any;
    logic [BITADDR-1:0] w_wr_adr;
    logic [BITDATA-1:0] w_wr_din;
    logic               w_rd_win;
    logic               w_rd_any;
    logic [BITADDR-1:0] w_rd_adr;
    logic               w_hazard;
    logic               w_rd_go;
    logic               w_rsp_vld;
    logic               w_rsp_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RST;
            r_icnt  <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_RST: begin
                    r_icnt <= '0;
                    if (RSTINIT != 0) begin
                        r_state <= ST_INIT;
                    end else begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_INIT: begin
                    if (r_icnt == LAST_ADR) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                        r_icnt  <= '0;
                    end else begin
                        r_icnt <= r_icnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready      = r_ready;
    assign w_run      = (r_state == ST_RUN);
    assign w_init     = (r_state == ST_INIT);
    assign w_init_din = BITDATA'(RSTSTRT + int'(r_icnt) * RSTINCR);

    // With both sides requesting the pointer picks the winner; otherwise the lone requester wins.
    assign w_wr_win = (wr_req_0 & wr_req_1) ? r_wp : wr_req_1;
    assign w_wr_any = w_run & (wr_req_0 | wr_req_1);
    assign w_wr_adr = w_wr_win ? wr_adr_1 : wr_adr_0;
    assign w_wr_din = w_wr_win ? wr_din_1 : wr_din_0;
    assign wr_gnt_0 = w_wr_any & ~w_wr_win;
    assign wr_gnt_1 = w_wr_any & w_wr_win;

    assign mem_write  = w_init | w_wr_any;
    assign mem_wr_adr = w_init ? r_icnt[BITADDR-1:0] : w_wr_adr;
    assign mem_wr_din = w_init ? w_init_din : w_wr_din;

    // A read to the address being written this cycle waits one cycle and sees the new data.
    assign w_rd_win = (rd_req_0 & rd_req_1) ? r_rp : rd_req_1;
    assign w_rd_any = w_run & (rd_req_0 | rd_req_1);
    assign w_rd_adr = w_rd_win ? rd_adr_1 : rd_adr_0;
    assign w_hazard = w_wr_any & (w_rd_adr == w_wr_adr);
    assign w_rd_go  = w_rd_any & ~w_hazard;
    assign rd_gnt_0 = w_rd_go & ~w_rd_win;
    assign rd_gnt_1 = w_rd_go & w_rd_win;

    assign mem_read   = w_rd_go;
    assign mem_rd_adr = w_rd_adr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= 1'b0;
            r_rp <= 1'b0;
        end else begin
            if (w_wr_any) r_wp <= ~w_wr_win;
            if (w_rd_go)  r_rp <= ~w_rd_win;
        end
    end

    generate
        if (SRAM_DELAY == 0) begin : g_rsp_comb
            assign w_rsp_vld = w_rd_go;
            assign w_rsp_id  = w_rd_win;
        end else begin : g_rsp_pipe
            logic [SRAM_DELAY-1:0] r_rsp_vld;
            logic [SRAM_DELAY-1:0] r_rsp_id;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rsp_vld <= '0;
                    r_rsp_id  <= '0;
                end else begin
                    for (int k = SRAM_DELAY - 1; k > 0; k--) begin
                        r_rsp_vld[k] <= r_rsp_vld[k-1];
                        r_rsp_id[k]  <= r_rsp_id[k-1];
                    end
                    r_rsp_vld[0] <= w_rd_go;
                    r_rsp_id[0]  <= w_rd_win;
                end
            end
            assign w_rsp_vld = r_rsp_vld[SRAM_DELAY-1];
            assign w_rsp_id  = r_rsp_id[SRAM_DELAY-1];
        end
    endgenerate

    assign rd_vld_0  = w_rsp_vld & ~w_rsp_id;
    assign rd_vld_1  = w_rsp_vld & w_rsp_id;
    assign rd_dout_0 = mem_rd_dout;
    assign rd_dout_1 = mem_rd_dout;

endmodule

// File: tb/tb_mem_1r1w_sched.sv
// Bench for mem_1r1w_sched: directed scenarios plus randomized traffic against a
// rule-level arbitration model and a shadow memory; includes a 2-cycle atom model.
module tb_mem_1r1w_sched;

    localparam int NA = 8;
    localparam int BA = 3;
    localparam int BD = 4;
    localparam int SD = 2;
    localparam int RSTSTRT = 3;
    localparam int RSTINCR = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ready;
    logic          rd_req_0, rd_req_1;
    logic [BA-1:0] rd_adr_0, rd_adr_1;
    logic          rd_gnt_0, rd_gnt_1, rd_vld_0, rd_vld_1;
    logic [BD-1:0] rd_dout_0, rd_dout_1;
    logic          wr_req_0, wr_req_1;
    logic [BA-1:0] wr_adr_0, wr_adr_1;
    logic [BD-1:0] wr_din_0, wr_din_1;
    logic          wr_gnt_0, wr_gnt_1;
    logic          mem_read, mem_write;
    logic [BA-1:0] mem_rd_adr, mem_wr_adr;
    logic [BD-1:0] mem_rd_dout, mem_wr_din;

    int n_chk  = 0;
    int n_pass = 0;
    int mdl_wp = 0;
    int mdl_rp = 0;
    logic [BD-1:0] ref_mem [NA];

    always #5 clk = ~clk;

    mem_1r1w_sched #(
        .NUMADDR(NA), .BITADDR(BA), .BITDATA(BD), .SRAM_DELAY(SD),
        .RSTINIT(1), .RSTSTRT(RSTSTRT), .RSTINCR(RSTINCR)
    ) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rd_req_0(rd_req_0), .rd_req_1(rd_req_1),
        .rd_adr_0(rd_adr_0), .rd_adr_1(rd_adr_1),
        .rd_gnt_0(rd_gnt_0), .rd_gnt_1(rd_gnt_1),
        .rd_vld_0(rd_vld_0), .rd_vld_1(rd_vld_1),
        .rd_dout_0(rd_dout_0), .rd_dout_1(rd_dout_1),
        .wr_req_0(wr_req_0), .wr_req_1(wr_req_1),
        .wr_adr_0(wr_adr_0), .wr_adr_1(wr_adr_1),
        .wr_din_0(wr_din_0), .wr_din_1(wr_din_1),
        .wr_gnt_0(wr_gnt_0), .wr_gnt_1(wr_gnt_1),
        .mem_read(mem_read), .mem_rd_adr(mem_rd_adr), .mem_rd_dout(mem_rd_dout),
        .mem_write(mem_write), .mem_wr_adr(mem_wr_adr), .mem_wr_din(mem_wr_din)
    );

    // Memory atom with a two-cycle read pipeline.
    logic [BD-1:0] atom_mem [NA];
    logic [BD-1:0] atom_s1 = '0;
    logic [BD-1:0] atom_s2 = '0;
    always @(posedge clk) begin
        if (mem_write) atom_mem[mem_wr_adr] <= mem_wr_din;
        if (mem_read)  atom_s1 <= atom_mem[mem_rd_adr];
        atom_s2 <= atom_s1;
    end
    assign mem_rd_dout = atom_s2;

    function automatic logic [BD-1:0] init_val(input int i);
        int v;
        v = (RSTSTRT + i * RSTINCR) % (1 << BD);
        return v[BD-1:0];
    endfunction

    task automatic idle();
        rd_req_0 = 0; rd_req_1 = 0; wr_req_0 = 0; wr_req_1 = 0;
        rd_adr_0 = '0; rd_adr_1 = '0; wr_adr_0 = '0; wr_adr_1 = '0;
        wr_din_0 = '0; wr_din_1 = '0;
    endtask

    task automatic model_after_init();
        for (int i = 0; i < NA; i++) ref_mem[i] = init_val(i);
        mdl_wp = 0;
        mdl_rp = 0;
    endtask

    task automatic test_reset();
        rd_req_0 = 1; rd_req_1 = 1; wr_req_0 = 1; wr_req_1 = 1;
        #12;
        n_chk++;
        if ({ready, rd_gnt_0, rd_gnt_1, wr_gnt_0, wr_gnt_1} !== 5'b0)
            $display("FAIL reset_ready_gnt got=%b want=00000",
                     {ready, rd_gnt_0, rd_gnt_1, wr_gnt_0, wr_gnt_1});
        else n_pass++;
        n_chk++;
        if ({mem_read, mem_write, rd_vld_0, rd_vld_1} !== 4'b0)
            $display("FAIL reset_mem_vld got=%b want=0000", {mem_read, mem_write, rd_vld_0, rd_vld_1});
        else n_pass++;
        $display("reset: ready=%b mem_read=%b mem_write=%b", ready, mem_read, mem_write);
        idle();
        @(posedge clk); #1 rst = 0;
    endtask

    task automatic test_init_sweep();
        for (int i = 0; i < NA; i++) begin
            @(posedge clk); #1;
            n_chk++;
            if ({ready, mem_read, mem_write, mem_wr_adr, mem_wr_din} !==
                {1'b0, 1'b0, 1'b1, 3'(i), init_val(i)})
                $display("FAIL init_write[%0d] got rdy=%b rd=%b wr=%b adr=%0d din=%0d want rdy=0 rd=0 wr=1 adr=%0d din=%0d",
                         i, ready, mem_read, mem_write, mem_wr_adr, mem_wr_din, i, init_val(i));
            else n_pass++;
            $display("init: adr=%0d din=%0d", mem_wr_adr, mem_wr_din);
        end
        @(posedge clk); #1;
        n_chk++;
        if ({ready, mem_write} !== 2'b10)
            $display("FAIL init_ready got ready=%b mem_write=%b want ready=1 mem_write=0", ready, mem_write);
        else n_pass++;
        model_after_init();
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            rd_req_0 = (c < 4);
            rd_req_1 = 1;
            rd_adr_0 = 3'($urandom_range(0, NA - 1));
            rd_adr_1 = 3'($urandom_range(0, NA - 1));
            #3;
            want = (c < 4 && (c % 2) == 0) ? 2'b01 : 2'b10;
            n_chk++;
            if ({rd_gnt_1, rd_gnt_0} !== want)
                $display("FAIL rr_grant[%0d] got=%b want=%b", c, {rd_gnt_1, rd_gnt_0}, want);
            else n_pass++;
            $display("rr: cycle=%0d gnt1=%b gnt0=%b", c, rd_gnt_1, rd_gnt_0);
        end
        mdl_rp = 0;
        @(posedge clk); #1 idle();
        repeat (3) @(posedge clk);
    endtask

    task automatic test_hazard();
        @(posedge clk); #1;
        wr_req_0 = 1; wr_adr_0 = 3'd5; wr_din_0 = 4'd1;
        rd_req_0 = 1; rd_adr_0 = 3'd5;
        #3;
        n_chk++;
        if ({wr_gnt_0, rd_gnt_0, mem_read} !== 3'b100)
            $display("FAIL hazard_hold got wgnt=%b rgnt=%b mrd=%b want 1 0 0", wr_gnt_0, rd_gnt_0, mem_read);
        else n_pass++;
        @(posedge clk); #1 wr_req_0 = 0;
        #3;
        n_chk++;
        if ({rd_gnt_0, mem_read, mem_rd_adr, wr_gnt_0} !== {1'b1, 1'b1, 3'd5, 1'b0})
            $display("FAIL hazard_retry got rgnt=%b mrd=%b adr=%0d wgnt=%b want 1 1 5 0",
                     rd_gnt_0, mem_read, mem_rd_adr, wr_gnt_0);
        else n_pass++;
        @(posedge clk); #1 rd_req_0 = 0;
        #3;
        n_chk++;
        if (rd_vld_0 !== 1'b0) $display("FAIL hazard_early_vld got=%b want=0", rd_vld_0);
        else n_pass++;
        @(posedge clk); #4;
        n_chk++;
        if ({rd_vld_0, rd_vld_1, rd_dout_0} !== {1'b1, 1'b0, 4'd1})
            $display("FAIL hazard_data got vld0=%b vld1=%b dout=%0d want 1 0 1", rd_vld_0, rd_vld_1, rd_dout_0);
        else n_pass++;
        $display("hazard: rd_vld_0=%b dout=%0d", rd_vld_0, rd_dout_0);
        ref_mem[5] = 4'd1;
        mdl_wp = 1;
        mdl_rp = 1;
        @(posedge clk); #1 idle();
    endtask

    task automatic test_back_to_back();
        logic [BA-1:0] ax, ay;
        ax = 3'($urandom_range(0, NA - 1));
        ay = 3'($urandom_range(0, NA - 1));
        @(posedge clk); #1 rd_req_1 = 1; rd_adr_1 = ax;
        #3;
        n_chk++;
        if ({rd_gnt_1, rd_gnt_0} !== 2'b10) $display("FAIL b2b_gnt1 got=%b want=10", {rd_gnt_1, rd_gnt_0});
        else n_pass++;
        @(posedge clk); #1 rd_req_1 = 0; rd_req_0 = 1; rd_adr_0 = ay;
        #3;
        n_chk++;
        if ({rd_gnt_1, rd_gnt_0, rd_vld_1, rd_vld_0} !== 4'b0100)
            $display("FAIL b2b_gnt0 got=%b want=0100", {rd_gnt_1, rd_gnt_0, rd_vld_1, rd_vld_0});
        else n_pass++;
        @(posedge clk); #1 rd_req_0 = 0;
        #3;
        n_chk++;
        if ({rd_vld_1, rd_vld_0, rd_dout_1} !== {2'b10, ref_mem[ax]})
            $display("FAIL b2b_vld1 got vld=%b dout=%0d want vld=10 dout=%0d",
                     {rd_vld_1, rd_vld_0}, rd_dout_1, ref_mem[ax]);
        else n_pass++;
        $display("b2b: req1 adr=%0d dout=%0d", ax, rd_dout_1);
        @(posedge clk); #4;
        n_chk++;
        if ({rd_vld_1, rd_vld_0, rd_dout_0} !== {2'b01, ref_mem[ay]})
            $display("FAIL b2b_vld0 got vld=%b dout=%0d want vld=01 dout=%0d",
                     {rd_vld_1, rd_vld_0}, rd_dout_0, ref_mem[ay]);
        else n_pass++;
        $display("b2b: req0 adr=%0d dout=%0d", ay, rd_dout_0);
        @(posedge clk); #4;
        n_chk++;
        if ({rd_vld_1, rd_vld_0} !== 2'b00) $display("FAIL b2b_tail got=%b want=00", {rd_vld_1, rd_vld_0});
        else n_pass++;
        mdl_rp = 1;
    endtask

    task automatic test_random();
        logic          rq [2], wq [2];
        logic [BA-1:0] ra [2], wa [2];
        logic [BD-1:0] wd [2];
        logic          rg [2], wg [2];
        int  wwin, rwin;
        logic wany, rany, haz, rgo;
        logic p1_v, p2_v;
        int   p1_id, p2_id;
        logic [BD-1:0] p1_d, p2_d;
        logic [3:0] eg;
        p1_v = 0; p2_v = 0; p1_id = 0; p2_id = 0; p1_d = '0; p2_d = '0;
        for (int k = 0; k < 2; k++) begin
            rq[k] = 0; wq[k] = 0; ra[k] = '0; wa[k] = '0; wd[k] = '0; rg[k] = 0; wg[k] = 0;
        end
        for (int c = 0; c < 170; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (!rq[k] || rg[k]) begin
                    rq[k] = (c < 160) && ($urandom_range(0, 3) != 0);
                    ra[k] = 3'($urandom_range(0, NA - 1));
                end
                if (!wq[k] || wg[k]) begin
                    wq[k] = (c < 160) && ($urandom_range(0, 2) != 0);
                    wa[k] = 3'($urandom_range(0, NA - 1));
                    wd[k] = 4'($urandom_range(0, 15));
                end
            end
            rd_req_0 = rq[0]; rd_req_1 = rq[1]; rd_adr_0 = ra[0]; rd_adr_1 = ra[1];
            wr_req_0 = wq[0]; wr_req_1 = wq[1]; wr_adr_0 = wa[0]; wr_adr_1 = wa[1];
            wr_din_0 = wd[0]; wr_din_1 = wd[1];
            #3;
            wany = wq[0] | wq[1];
            wwin = (wq[0] && wq[1]) ? mdl_wp : (wq[1] ? 1 : 0);
            rany = rq[0] | rq[1];
            rwin = (rq[0] && rq[1]) ? mdl_rp : (rq[1] ? 1 : 0);
            haz  = wany && (ra[rwin] == wa[wwin]);
            rgo  = rany && !haz;
            eg   = {wany && wwin == 1, wany && wwin == 0, rgo && rwin == 1, rgo && rwin == 0};
            n_chk++;
            if ({wr_gnt_1, wr_gnt_0, rd_gnt_1, rd_gnt_0} !== eg)
                $display("FAIL rand_gnt[%0d] got=%b want=%b", c, {wr_gnt_1, wr_gnt_0, rd_gnt_1, rd_gnt_0}, eg);
            else n_pass++;
            n_chk++;
            if ({mem_write, mem_write ? mem_wr_adr : 3'd0, mem_write ? mem_wr_din : 4'd0,
                 mem_read, mem_read ? mem_rd_adr : 3'd0} !==
                {wany, wany ? wa[wwin] : 3'd0, wany ? wd[wwin] : 4'd0, rgo, rgo ? ra[rwin] : 3'd0})
                $display("FAIL rand_port[%0d] got wr=%b adr=%0d din=%0d rd=%b adr=%0d want wr=%b adr=%0d din=%0d rd=%b adr=%0d",
                         c, mem_write, mem_wr_adr, mem_wr_din, mem_read, mem_rd_adr,
                         wany, wa[wwin], wd[wwin], rgo, ra[rwin]);
            else n_pass++;
            n_chk++;
            if ({rd_vld_1, rd_vld_0} !== {p2_v && p2_id == 1, p2_v && p2_id == 0} ||
                (p2_v && (p2_id == 1 ? rd_dout_1 : rd_dout_0) !== p2_d))
                $display("FAIL rand_rsp[%0d] got vld=%b dout=%0d want vld=%b dout=%0d", c,
                         {rd_vld_1, rd_vld_0}, rd_dout_0, {p2_v && p2_id == 1, p2_v && p2_id == 0}, p2_d);
            else n_pass++;
            $display("rand: cycle=%0d wgnt=%b%b rgnt=%b%b haz=%b vld=%b%b", c,
                     wr_gnt_1, wr_gnt_0, rd_gnt_1, rd_gnt_0, haz, rd_vld_1, rd_vld_0);
            p2_v = p1_v; p2_id = p1_id; p2_d = p1_d;
            p1_v = rgo; p1_id = rwin; p1_d = ref_mem[ra[rwin]];
            if (wany) begin
                ref_mem[wa[wwin]] = wd[wwin];
                mdl_wp = 1 - wwin;
            end
            if (rgo) mdl_rp = 1 - rwin;
            for (int k = 0; k < 2; k++) begin
                rg[k] = rgo && rwin == k;
                wg[k] = wany && wwin == k;
            end
        end
        @(posedge clk); #1 idle();
    endtask

    task automatic test_mid_reset();
        @(posedge clk); #1 rd_req_0 = 1; rd_adr_0 = 3'd2;
        @(posedge clk); #1 rd_req_0 = 0; rd_req_1 = 1; rd_adr_1 = 3'd6;
        @(posedge clk); #1 idle(); rst = 1;
        #1;
        n_chk++;
        if ({ready, rd_vld_0, rd_vld_1} !== 3'b000)
            $display("FAIL midrst_now got rdy=%b vld=%b%b want 0 00", ready, rd_vld_1, rd_vld_0);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #4;
            n_chk++;
            if ({rd_vld_0, rd_vld_1, mem_write, ready} !== 4'b0)
                $display("FAIL midrst_drop[%0d] got=%b want=0000", c, {rd_vld_0, rd_vld_1, mem_write, ready});
            else n_pass++;
        end
        $display("midrst: in-flight reads dropped");
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_chk++;
            if ({mem_write, mem_wr_adr} !== {1'b1, 3'(i)})
                $display("FAIL midrst_init1[%0d] got wr=%b adr=%0d want wr=1 adr=%0d", i, mem_write, mem_wr_adr, i);
            else n_pass++;
        end
        #1 rst = 1;
        #1;
        n_chk++;
        if ({mem_write, ready} !== 2'b00)
            $display("FAIL midrst_abort got wr=%b rdy=%b want 0 0", mem_write, ready);
        else n_pass++;
        $display("midrst: init aborted at adr 4");
        @(posedge clk); #1 rst = 0;
        test_init_sweep();
    endtask

    initial begin
        idle();
        test_reset();
        test_init_sweep();
        test_round_robin();
        test_hazard();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
